logical_tile_clb_param: RTL

//   Parametrised CLB: N_FLE fracturable logic elements, each a K-input LUT with an optional output FF.
//   A local crossbar feeds every LUT input from either a CLB input or any FLE output (feedback).

---
 rtl/logical_tile_clb_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/logical_tile_clb_param.sv
// Parametrised CLB tile: N_FLE LUT+FF elements, a local crossbar with FLE feedback and a
// serial configuration chain whose load is tracked by a small FSM. Outputs stay at 0 until
// a bitstream of exactly CFG_BITS bits has been shifted in.
module logical_tile_clb_param #(
    parameter int N_FLE = 2,
    parameter int K     = 4,
    parameter int NUM_I = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_I-1:0] clb_I,
    input  logic             ccff_en,
    input  logic             ccff_head,
    output logic [N_FLE-1:0] clb_O,
    output logic             ccff_tail,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int NSRC     = NUM_I + N_FLE;
    localparam int S        = $clog2(NSRC);
    localparam int TW       = 2 ** K;
    localparam int FB       = TW + 1;
    localparam int MUX_BASE = N_FLE * FB;
    localparam int CFG_BITS = N_FLE * FB + N_FLE * K * S;
    localparam int CW       = $clog2(CFG_BITS + 2);

    localparam logic [1:0] ST_UNCFG  = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [CFG_BITS-1:0] r_cfg;
    logic [N_FLE-1:0]    r_ff;
    logic [1:0]          r_state;
    logic [CW-1:0]       r_count;
    logic                r_err;

    logic [1:0]          w_state_nx;
    logic [CW-1:0]       w_count_nx;
    logic                w_err_nx;
    logic [N_FLE-1:0]    w_lut_out;
    logic [N_FLE-1:0]    w_fle_out;

    // Configuration shift register; shifts whenever enabled, regardless of state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg <= '0;
        end else if (ccff_en) begin
            r_cfg <= {r_cfg[CFG_BITS-2:0], ccff_head};
        end
    end

    // Crossbar and LUTs. Feedback between combinational FLEs is resolved by unrolling
    // N_FLE+1 passes: any legal (acyclic) chain settles within N_FLE passes, and the
    // extra pass gives FF-mode LUTs their final inputs. No combinational loop is built.
    always_comb begin
        logic [N_FLE-1:0] w_fb;
        logic [NSRC-1:0]  w_src;
        logic [K-1:0]     w_addr;
        logic [S-1:0]     w_sel;
        logic [TW-1:0]    w_tab;
        w_fb      = '0;
        w_src     = '0;
        w_addr    = '0;
        w_sel     = '0;
        w_tab     = '0;
        w_lut_out = '0;
        for (int j = 0; j < N_FLE; j++) begin
            w_fb[j] = r_cfg[j*FB+TW] & r_ff[j];
        end
        for (int p = 0; p <= N_FLE; p++) begin
            w_src = {w_fb, clb_I};
            for (int j = 0; j < N_FLE; j++) begin
                w_tab = r_cfg[j*FB +: TW];
                for (int k = 0; k < K; k++) begin
                    w_sel     = r_cfg[MUX_BASE + (j*K+k)*S +: S];
                    // Selects beyond the source vector read constant 0.
                    w_addr[k] = (int'(w_sel) < NSRC) ? w_src[w_sel] : 1'b0;
                end
                w_lut_out[j] = w_tab[w_addr];
            end
            for (int j = 0; j < N_FLE; j++) begin
                w_fb[j] = r_cfg[j*FB+TW] ? r_ff[j] : w_lut_out[j];
            end
        end
        w_fle_out = w_fb;
    end

    // FLE flops capture LUT outputs only while active; held clear otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ff <= '0;
        end else if (r_state == ST_ACTIVE) begin
            r_ff <= w_lut_out;
        end else begin
            r_ff <= '0;
        end
    end

    // Load FSM next-state: counts shifted bits and judges the length when enable drops.
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_err_nx   = r_err;
        case (r_state)
            ST_UNCFG: begin
                if (ccff_en) begin
                    w_state_nx = ST_LOAD;
                    w_count_nx = CW'(1);
                end
            end
            ST_LOAD: begin
                if (ccff_en) begin
                    if (r_count != CW'(CFG_BITS + 1)) begin
                        w_count_nx = r_count + CW'(1);
                    end
                end else if (r_count == CW'(CFG_BITS)) begin
                    w_state_nx = ST_ACTIVE;
                    w_count_nx = '0;
                    w_err_nx   = 1'b0;
                end else begin
                    w_state_nx = ST_UNCFG;
                    w_count_nx = '0;
                    w_err_nx   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ccff_en) begin
                    w_state_nx = ST_LOAD;
                    w_count_nx = CW'(1);
                end
            end
            default: begin
                w_state_nx = ST_UNCFG;
                w_count_nx = '0;
            end
        endcase
    end

    // Load FSM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_UNCFG;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_err   <= w_err_nx;
        end
    end

    assign clb_O     = (r_state == ST_ACTIVE) ? w_fle_out : '0;
    assign ccff_tail = r_cfg[CFG_BITS-1];
    assign cfg_done  = (r_state == ST_ACTIVE);
    assign cfg_err   = r_err;

endmodule
